// File: rtl/accel_bcd_formatter.sv
// Snapshots four averaged accelerometer channels and converts them to sign + packed BCD.
// One shared double-dabble engine runs X, Y, Z, T in turn; all results are published together.
module accel_bcd_formatter #(
    parameter int XYZ_WIDTH = 12,
    parameter int T_WIDTH   = 19
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_AVG_Ready,
    input  logic [XYZ_WIDTH-1:0] i_AVG_AccelX,
    input  logic [XYZ_WIDTH-1:0] i_AVG_AccelY,
    input  logic [XYZ_WIDTH-1:0] i_AVG_AccelZ,
    input  logic [T_WIDTH-1:0]   i_AVG_AccelT,
    output logic [15:0]          o_BCD_X,
    output logic [15:0]          o_BCD_Y,
    output logic [15:0]          o_BCD_Z,
    output logic [23:0]          o_BCD_T,
    output logic [3:0]           o_BCD_Sign,
    output logic                 o_BCD_Ready,
    output logic                 o_BCD_Busy,
    output logic                 o_BCD_Dropped
);

    generate
        if (XYZ_WIDTH != 12 || T_WIDTH != 19) begin : g_bad_width
            $error("accel_bcd_formatter: only XYZ_WIDTH=12 and T_WIDTH=19 are supported");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;
    localparam logic [1:0] CH_X = 2'd0, CH_Y = 2'd1, CH_Z = 2'd2, CH_T = 2'd3;

    state_t               state_q;
    logic [1:0]           ch_q;
    logic [XYZ_WIDTH-1:0] snap_x_q, snap_y_q, snap_z_q;
    logic [T_WIDTH-1:0]   snap_t_q;
    logic [T_WIDTH-1:0]   mag_q, mag_d;
    logic [23:0]          bcd_q, bcd_d;
    logic [4:0]           cnt_q;
    logic                 neg_q;
    logic [15:0]          wrk_x_q, wrk_y_q, wrk_z_q;
    logic [2:0]           wrk_sign_q;

    logic [19:0]          sel_v;
    logic [T_WIDTH-1:0]   mag_v;
    logic [23:0]          adj_v;
    logic [42:0]          acc_v;
    logic                 sign_v;

    // Selected channel, sign-extended to 20 bits; magnitude fits 19 bits even for the most-negative input.
    always_comb begin
        case (ch_q)
            CH_X:    sel_v = {{(20-XYZ_WIDTH){snap_x_q[XYZ_WIDTH-1]}}, snap_x_q};
            CH_Y:    sel_v = {{(20-XYZ_WIDTH){snap_y_q[XYZ_WIDTH-1]}}, snap_y_q};
            CH_Z:    sel_v = {{(20-XYZ_WIDTH){snap_z_q[XYZ_WIDTH-1]}}, snap_z_q};
            default: sel_v = {snap_t_q[T_WIDTH-1], snap_t_q};
        endcase
        mag_v = sel_v[19] ? (~sel_v[T_WIDTH-1:0] + 19'd1) : sel_v[T_WIDTH-1:0];
    end

    always_comb begin
        adj_v = bcd_q;
        for (int i = 0; i < 6; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                adj_v[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        acc_v = {adj_v, mag_q} << 1;
        bcd_d = acc_v[42:19];
        mag_d = acc_v[18:0];
    end

    // A zero magnitude never reports as negative.
    assign sign_v = neg_q & (|bcd_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ch_q          <= CH_X;
            snap_x_q      <= '0;
            snap_y_q      <= '0;
            snap_z_q      <= '0;
            snap_t_q      <= '0;
            mag_q         <= '0;
            bcd_q         <= '0;
            cnt_q         <= '0;
            neg_q         <= 1'b0;
            wrk_x_q       <= '0;
            wrk_y_q       <= '0;
            wrk_z_q       <= '0;
            wrk_sign_q    <= '0;
            o_BCD_X       <= '0;
            o_BCD_Y       <= '0;
            o_BCD_Z       <= '0;
            o_BCD_T       <= '0;
            o_BCD_Sign    <= '0;
            o_BCD_Ready   <= 1'b0;
            o_BCD_Busy    <= 1'b0;
            o_BCD_Dropped <= 1'b0;
        end else begin
            o_BCD_Ready   <= 1'b0;
            o_BCD_Dropped <= i_AVG_Ready && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (i_AVG_Ready) begin
                        snap_x_q   <= i_AVG_AccelX;
                        snap_y_q   <= i_AVG_AccelY;
                        snap_z_q   <= i_AVG_AccelZ;
                        snap_t_q   <= i_AVG_AccelT;
                        ch_q       <= CH_X;
                        o_BCD_Busy <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    neg_q   <= sel_v[19];
                    mag_q   <= mag_v;
                    bcd_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    bcd_q <= bcd_d;
                    mag_q <= mag_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(T_WIDTH - 1))
                        state_q <= STORE;
                end
                STORE: begin
                    case (ch_q)
                        CH_X: begin wrk_x_q <= bcd_q[15:0]; wrk_sign_q[0] <= sign_v; end
                        CH_Y: begin wrk_y_q <= bcd_q[15:0]; wrk_sign_q[1] <= sign_v; end
                        CH_Z: begin wrk_z_q <= bcd_q[15:0]; wrk_sign_q[2] <= sign_v; end
                        default: ;
                    endcase
                    if (ch_q != CH_T) begin
                        ch_q    <= ch_q + 2'd1;
                        state_q <= LOAD;
                    end else begin
                        // Publish all four channels on the same edge so the display never sees a mix.
                        o_BCD_X     <= wrk_x_q;
                        o_BCD_Y     <= wrk_y_q;
                        o_BCD_Z     <= wrk_z_q;
                        o_BCD_T     <= bcd_q;
                        o_BCD_Sign  <= {sign_v, wrk_sign_q};
                        o_BCD_Ready <= 1'b1;
                        o_BCD_Busy  <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accel_bcd_formatter.sv
// Bench for accel_bcd_formatter: directed cases plus randomized back-to-back conversions
// checked against a decimal-arithmetic reference.
module tb_accel_bcd_formatter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_AVG_Ready;
    logic [11:0] i_AVG_AccelX, i_AVG_AccelY, i_AVG_AccelZ;
    logic [18:0] i_AVG_AccelT;
    logic [15:0] o_BCD_X, o_BCD_Y, o_BCD_Z;
    logic [23:0] o_BCD_T;
    logic [3:0]  o_BCD_Sign;
    logic        o_BCD_Ready, o_BCD_Busy, o_BCD_Dropped;

    int nchk = 0;
    int nerr = 0;

    logic [15:0] ex, ey, ez;
    logic [23:0] et;
    logic [3:0]  es;

    accel_bcd_formatter #(.XYZ_WIDTH(12), .T_WIDTH(19)) dut (
        .clk(clk), .reset(reset), .i_AVG_Ready(i_AVG_Ready),
        .i_AVG_AccelX(i_AVG_AccelX), .i_AVG_AccelY(i_AVG_AccelY),
        .i_AVG_AccelZ(i_AVG_AccelZ), .i_AVG_AccelT(i_AVG_AccelT),
        .o_BCD_X(o_BCD_X), .o_BCD_Y(o_BCD_Y), .o_BCD_Z(o_BCD_Z), .o_BCD_T(o_BCD_T),
        .o_BCD_Sign(o_BCD_Sign), .o_BCD_Ready(o_BCD_Ready),
        .o_BCD_Busy(o_BCD_Busy), .o_BCD_Dropped(o_BCD_Dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits by repeated division.
    function automatic logic [23:0] bcd_of(input int v);
        int m;
        logic [23:0] r;
        m = (v < 0) ? -v : v;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic digits_ok(input logic [23:0] b);
        for (int i = 0; i < 6; i++)
            if (b[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] outs_match();
        return {31'd0, (o_BCD_X === ex) && (o_BCD_Y === ey) && (o_BCD_Z === ez) &&
                       (o_BCD_T === et) && (o_BCD_Sign === es)};
    endfunction

    task automatic scramble_inputs();
        i_AVG_AccelX = 12'($urandom);
        i_AVG_AccelY = 12'($urandom);
        i_AVG_AccelZ = 12'($urandom);
        i_AVG_AccelT = 19'($urandom);
    endtask

    // Called on a negedge; the accepting edge is the next posedge (edge 0).
    task automatic run_conv(input int x, input int y, input int z, input int t,
                            input int drop_at, input int rst_at);
        int cyc, drops, bad_busy, bad_hold, rdy_after;
        bit seen, aborted;
        i_AVG_AccelX = x[11:0];
        i_AVG_AccelY = y[11:0];
        i_AVG_AccelZ = z[11:0];
        i_AVG_AccelT = t[18:0];
        i_AVG_Ready  = 1'b1;
        @(negedge clk);
        i_AVG_Ready = 1'b0;
        scramble_inputs();
        chk("ready_one_cycle", {31'd0, o_BCD_Ready}, 0);
        chk("busy_at_accept", {31'd0, o_BCD_Busy}, 1);
        chk("no_drop_at_accept", {31'd0, o_BCD_Dropped}, 0);
        cyc = 0; drops = 0; bad_busy = 0; bad_hold = 0; seen = 0; aborted = 0;
        while (cyc < 200 && !seen && !aborted) begin
            i_AVG_Ready = (drop_at != 0 && cyc == drop_at - 1);
            reset       = (rst_at != 0 && cyc == rst_at - 1);
            @(negedge clk);
            cyc++;
            i_AVG_Ready = 1'b0;
            if (o_BCD_Dropped) drops++;
            if (rst_at != 0 && cyc == rst_at) begin
                aborted = 1;
                reset = 1'b0;
                chk("rst_x", {16'd0, o_BCD_X}, 0);
                chk("rst_y", {16'd0, o_BCD_Y}, 0);
                chk("rst_z", {16'd0, o_BCD_Z}, 0);
                chk("rst_t", {8'd0, o_BCD_T}, 0);
                chk("rst_sign", {28'd0, o_BCD_Sign}, 0);
                chk("rst_busy", {31'd0, o_BCD_Busy}, 0);
                chk("rst_ready", {31'd0, o_BCD_Ready}, 0);
                ex = '0; ey = '0; ez = '0; et = '0; es = '0;
                rdy_after = 0;
                repeat (100) begin
                    @(negedge clk);
                    if (o_BCD_Ready) rdy_after++;
                end
                chk("no_ready_after_abort", rdy_after, 0);
            end else if (o_BCD_Ready) begin
                seen = 1;
            end else begin
                if (!o_BCD_Busy) bad_busy++;
                if (!outs_match()) bad_hold++;
            end
        end
        if (!aborted) begin
            ex = bcd_of(x)[15:0];
            ey = bcd_of(y)[15:0];
            ez = bcd_of(z)[15:0];
            et = bcd_of(t);
            es = {t < 0, z < 0, y < 0, x < 0};
            chk("latency", cyc, 84);
            chk("bcd_x", {16'd0, o_BCD_X}, {16'd0, ex});
            chk("bcd_y", {16'd0, o_BCD_Y}, {16'd0, ey});
            chk("bcd_z", {16'd0, o_BCD_Z}, {16'd0, ez});
            chk("bcd_t", {8'd0, o_BCD_T}, {8'd0, et});
            chk("sign", {28'd0, o_BCD_Sign}, {28'd0, es});
            chk("digits_valid", {31'd0, digits_ok(o_BCD_T) &
                                 digits_ok({8'd0, o_BCD_X}) & digits_ok({8'd0, o_BCD_Y}) &
                                 digits_ok({8'd0, o_BCD_Z})}, 1);
            chk("busy_falls_with_ready", {31'd0, o_BCD_Busy}, 0);
            chk("busy_held", bad_busy, 0);
            chk("outputs_held", bad_hold, 0);
            chk("drop_pulses", drops, (drop_at != 0) ? 1 : 0);
        end
    endtask

    function automatic int rnd_xyz();
        case ($urandom_range(0, 7))
            0: return -2048;
            1: return 2047;
            2: return 0;
            default: return int'($urandom_range(0, 4095)) - 2048;
        endcase
    endfunction

    function automatic int rnd_t();
        case ($urandom_range(0, 7))
            0: return -262144;
            1: return 262143;
            2: return 0;
            default: return int'($urandom_range(0, 524287)) - 262144;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        i_AVG_Ready = 1'b0;
        i_AVG_AccelX = '0; i_AVG_AccelY = '0; i_AVG_AccelZ = '0; i_AVG_AccelT = '0;
        ex = '0; ey = '0; ez = '0; et = '0; es = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs_match(), 1);
        chk("reset_ready", {31'd0, o_BCD_Ready}, 0);
        chk("reset_busy", {31'd0, o_BCD_Busy}, 0);
        chk("reset_dropped", {31'd0, o_BCD_Dropped}, 0);
        reset = 1'b0;
        @(negedge clk);

        run_conv(1234, -2048, 0, -262144, 0, 0);
        chk("t1_x_const", {16'd0, o_BCD_X}, 32'h1234);
        chk("t1_t_const", {8'd0, o_BCD_T}, 32'h262144);
        chk("t1_sign_const", {28'd0, o_BCD_Sign}, 32'b1010);
        repeat (3) @(negedge clk);

        run_conv(2047, -1, -999, 262143, 0, 0);
        chk("t2_z_const", {16'd0, o_BCD_Z}, 32'h0999);
        chk("t2_sign_const", {28'd0, o_BCD_Sign}, 32'b0110);
        repeat (2) @(negedge clk);

        run_conv(-321, 45, -6, 98765, 40, 0);
        // Back-to-back: next request lands on the first non-busy cycle.
        run_conv(-7, 800, -1500, -12345, 0, 0);

        repeat (2) @(negedge clk);
        run_conv(111, 222, 333, 444, 0, 50);
        run_conv(5, 0, 0, 0, 0, 0);
        chk("t5_x_const", {16'd0, o_BCD_X}, 32'h0005);

        for (int n = 0; n < 1000; n++)
            run_conv(rnd_xyz(), rnd_xyz(), rnd_xyz(), rnd_t(), 0, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/accel_bcd_formatter.md
Name: accel_bcd_formatter

Overview:
- Downstream consumer of the averaging stage.
- Snapshots the four averaged channels (X, Y, Z signed 12-bit; T signed 19-bit) on the averaging stage's ready pulse.
- Converts each channel to sign + packed BCD magnitude using one shared, iterative shift-add-3 (double-dabble) engine, one channel at a time, in the order X, Y, Z, T.
- Presents all four results atomically with a one-cycle ready pulse to the 7-segment/UART display logic.

Parameters:
- XYZ_WIDTH, 12, signed width of X/Y/Z inputs. Fixed for this revision; elaboration error if ≠ 12.
- T_WIDTH, 19, signed width of T input; also the engine iteration count. Fixed for this revision; elaboration error if ≠ 19.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_AVG_Ready  in  1  one-cycle pulse; averaged data on the i_AVG_Accel* inputs is valid this cycle.
- i_AVG_AccelX  in  12  signed X average.
- i_AVG_AccelY  in  12  signed Y average.
- i_AVG_AccelZ  in  12  signed Z average.
- i_AVG_AccelT  in  19  signed T average.
- o_BCD_X  out  16  4-digit packed BCD magnitude of X.
- o_BCD_Y  out  16  4-digit packed BCD magnitude of Y.
- o_BCD_Z  out  16  4-digit packed BCD magnitude of Z.
- o_BCD_T  out  24  6-digit packed BCD magnitude of T.
- o_BCD_Sign  out  4  negative flags {T,Z,Y,X}; 1 = negative.
- o_BCD_Ready  out  1  one-cycle pulse; all o_BCD_* outputs updated this cycle.
- o_BCD_Busy  out  1  high while a conversion is in progress.
- o_BCD_Dropped  out  1  one-cycle pulse when i_AVG_Ready arrives while busy.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0; FSM goes to IDLE; snapshot, working and shift registers are cleared.
  - Reset wins over every other event, including mid-conversion.
  - No o_BCD_Ready is produced for an aborted conversion, and outputs do not hold partial results.
- FSM states: IDLE, LOAD, SHIFT, STORE.
- IDLE:
  - o_BCD_Busy = 0.
  - When i_AVG_Ready = 1 at an edge (edge 0), capture all four inputs into snapshot registers, set channel index = X, go to LOAD.
- LOAD (one edge):
  - Sign-extend the selected channel to 20 bits.
  - sign = MSB; magnitude = sign ? -value : value, kept as 19-bit unsigned. Most-negative inputs are legal: -2048 gives 2048, -262144 gives 262144.
  - Clear the 24-bit BCD accumulator, clear the iteration counter, go to SHIFT.
- SHIFT (exactly 19 edges, X/Y/Z included; their upper magnitude bits are 0):
  - For each BCD nibble ≥ 5, add 3.
  - Then shift {bcd, magnitude} left by one.
  - Increment the counter; after the 19th shift go to STORE.
- STORE (one edge):
  - Write the BCD accumulator and sign into working result registers for the current channel. X/Y/Z keep the low 16 bits; their upper 8 bits are always 0.
  - A magnitude of 0 always stores sign 0.
  - If channel ≠ T: advance the channel and go to LOAD.
  - If channel = T: load all o_BCD_X/Y/Z/T and o_BCD_Sign from the working registers plus the T result on this same edge, set o_BCD_Ready = 1, go to IDLE.
- Timing:
  - Each channel takes 21 edges: X on edges 1–21, Y on 22–42, Z on 43–63, T on 64–84.
  - o_BCD_Ready is high in the cycle after edge 84 and is cleared at edge 85.
  - Latency = 84 clocks from the accepting edge.
  - A new i_AVG_Ready is accepted from edge 85 onward (back-to-back allowed).
- Busy and drop handling:
  - o_BCD_Busy = 1 from edge 0 through edge 84 (registered; falls with the ready pulse).
  - i_AVG_Ready while state ≠ IDLE is ignored: the snapshot is untouched, the conversion continues, and o_BCD_Dropped pulses for one cycle.
- Output hold: o_BCD_* hold their values between conversions and change only on the final STORE edge.
- Input changes after the accepting edge have no effect on the conversion in progress.

Test Plan:
1. Reset, then pulse i_AVG_Ready with X=1234, Y=-2048, Z=0, T=-262144 -> exactly 84 clocks later o_BCD_Ready pulses for 1 cycle with o_BCD_X=16'h1234, o_BCD_Y=16'h2048, o_BCD_Z=16'h0000, o_BCD_T=24'h262144, o_BCD_Sign=4'b1010.
2. Extremes X=2047, Y=-1, Z=-999, T=262143 -> 16'h2047, 16'h0001, 16'h0999, 24'h262143, o_BCD_Sign=4'b0110.
3. Second i_AVG_Ready at edge 40 of a conversion -> o_BCD_Dropped pulses once; result matches the first snapshot only; o_BCD_Busy high edges 0–84.
4. Back-to-back: new pulse on the first cycle o_BCD_Busy=0 -> accepted with no drop; second ready pulse exactly 84 clocks after the second accept; outputs stable in between.
5. Assert reset at edge 50 of a conversion -> all outputs 0 the next cycle, no ready pulse; a subsequent pulse with X=5 yields o_BCD_X=16'h0005 after 84 clocks.
6. Random signed stimulus (≥1000 vectors) vs. a reference model -> BCD digits all ≤ 9, value and sign match exactly, ready spacing always 84.
